// File: rtl/seg7_msg_scroller.sv
// Scrolls a fixed 7-segment message across DIGITS displays, stepped by a
// debounced button and/or an auto-step prescaler, in either direction.
module seg7_msg_scroller #(
   parameter int unsigned          MSG_LEN    = 14,
   parameter int unsigned          DIGITS     = 4,
   parameter logic [8*MSG_LEN-1:0] MSG        = 112'h000E3E157E5F0E3E5F0E7E154F5B,
   parameter int unsigned          PRESC_W    = 24,
   parameter int unsigned          DEB_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       step_in,
   input  logic                       mode,
   input  logic                       dir,
   input  logic                       hold,
   input  logic [PRESC_W-1:0]         period,
   output logic [8*DIGITS-1:0]        seg_out,
   output logic [$clog2(MSG_LEN)-1:0] index,
   output logic                       wrap
);

   localparam int unsigned    IW       = $clog2(MSG_LEN);
   localparam int unsigned    CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [IW-1:0]  LAST     = IW'(MSG_LEN - 1);

   logic                 sync1;
   logic                 s;
   logic                 deb_level;
   logic [CW-1:0]        deb_cnt;
   logic                 deb_fire;
   logic                 man_step;
   logic [PRESC_W-1:0]   pcnt;
   logic                 auto_step;
   logic                 step;
   logic [IW-1:0]        index_next;
   logic                 wrap_next;
   logic [8*DIGITS-1:0]  window;
   int unsigned          pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= step_in;
         s     <= sync1;
      end
   end

   // The level flips on the same edge the step fires, so the step is decoded
   // combinationally from the flip condition rather than from a delayed level.
   assign deb_fire = (s != deb_level) && (deb_cnt == DEB_LAST);
   assign man_step = deb_fire && s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt   <= '0;
         deb_level <= 1'b0;
      end else if (s == deb_level) begin
         deb_cnt <= '0;
      end else if (deb_fire) begin
         deb_level <= s;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= deb_cnt + CW'(1);
      end
   end

   assign auto_step = mode && !hold && (pcnt == period);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (!mode || hold || (pcnt == period)) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PRESC_W'(1);
      end
   end

   assign step = man_step || auto_step;

   always_comb begin
      index_next = index;
      wrap_next  = 1'b0;
      if (step) begin
         if (dir) begin
            if (index == '0) begin
               index_next = LAST;
               wrap_next  = 1'b1;
            end else begin
               index_next = index - IW'(1);
            end
         end else begin
            if (index == LAST) begin
               index_next = '0;
               wrap_next  = 1'b1;
            end else begin
               index_next = index + IW'(1);
            end
         end
      end
   end

   // Window is built from index_next so the display moves on the step edge.
   always_comb begin
      window = '0;
      pos    = 0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         pos = 32'(index_next) + k;
         if (pos >= MSG_LEN) pos = pos - MSG_LEN;
         window[8*k +: 8] = MSG[8*pos +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index   <= '0;
         seg_out <= '0;
         wrap    <= 1'b0;
      end else begin
         index   <= index_next;
         seg_out <= window;
         wrap    <= wrap_next;
      end
   end

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Scoreboard bench for seg7_msg_scroller: stimulus queues expected steps,
// a negedge monitor pops and checks each observed index change.
module tb_seg7_msg_scroller;

   logic        clk;
   logic        rst_n;
   logic        step_in;
   logic        mode;
   logic        dir;
   logic        hold;
   logic [23:0] period;
   logic [31:0] seg_out;
   logic [3:0]  index;
   logic        wrap;

   seg7_msg_scroller #(
      .MSG_LEN    (14),
      .DIGITS     (4),
      .PRESC_W    (24),
      .DEB_CYCLES (16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_in (step_in),
      .mode    (mode),
      .dir     (dir),
      .hold    (hold),
      .period  (period),
      .seg_out (seg_out),
      .index   (index),
      .wrap    (wrap)
   );

   typedef struct {
      int   cyc;
      int   idx;
      logic wr;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   prev  = 0;
   int   c;

   logic [7:0] chars [14] = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E,
                              8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E, 8'h00};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] win(input int i);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = chars[(i + k) % 14];
      return w;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int cy, input int i, input logic w);
      exp_t e;
      e.cyc = cy;
      e.idx = i;
      e.wr  = w;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev = int'(index);
      end else if (int'(index) != prev) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_step: index %0d -> %0d, no step expected (cycle %0d)",
                     prev, index, cyc);
         end else begin
            e = q.pop_front();
            check("step_cycle", 64'(cyc), 64'(e.cyc));
            check("step_index", 64'(index), 64'(e.idx));
            check("step_seg", 64'(seg_out), 64'(win(e.idx)));
            check("step_wrap", 64'(wrap), 64'(e.wr));
         end
         prev = int'(index);
      end else begin
         check("wrap_idle", 64'(wrap), 64'(0));
      end
   end

   initial begin
      rst_n   = 1'b0;
      step_in = 1'b0;
      mode    = 1'b0;
      dir     = 1'b0;
      hold    = 1'b0;
      period  = 24'd3;
      repeat (3) tick();
      check("rst_index", 64'(index), 64'(0));
      check("rst_seg", 64'(seg_out), 64'(0));
      check("rst_wrap", 64'(wrap), 64'(0));

      rst_n = 1'b1;
      tick();
      check("init_index", 64'(index), 64'(0));
      check("init_seg", 64'(seg_out), 64'h7E154F5B);
      check("init_wrap", 64'(wrap), 64'(0));

      // debounced manual press, forward: 0 -> 1 on the 18th edge
      step_in = 1'b1;
      push(cyc + 18, 1, 1'b0);
      repeat (25) tick();
      step_in = 1'b0;
      repeat (25) tick();

      // 10-clock glitch: no step
      step_in = 1'b1;
      repeat (10) tick();
      step_in = 1'b0;
      repeat (25) tick();

      // auto forward, period 3: 13 steps 1 -> 0 with wrap on 13 -> 0
      mode   = 1'b1;
      period = 24'd3;
      dir    = 1'b0;
      c      = cyc;
      for (int k = 1; k <= 13; k++) push(c + 4*k, (1 + k) % 14, ((1 + k) % 14) == 0);
      repeat (52) tick();
      mode = 1'b0;
      repeat (5) tick();

      // manual reverse from 0: wraps to 13
      dir     = 1'b1;
      step_in = 1'b1;
      push(cyc + 18, 13, 1'b1);
      repeat (25) tick();
      step_in = 1'b0;
      repeat (25) tick();

      // auto with hold mid-count, then coincident manual+auto step
      dir  = 1'b0;
      mode = 1'b1;
      c    = cyc;
      push(c + 4, 0, 1'b1);
      push(c + 8, 1, 1'b0);
      repeat (10) tick();
      hold = 1'b1;
      repeat (20) tick();
      hold = 1'b0;
      c    = cyc;
      for (int k = 1; k <= 5; k++) push(c + 4*k, 1 + k, 1'b0);
      repeat (2) tick();
      step_in = 1'b1;
      repeat (18) tick();
      mode = 1'b0;
      repeat (5) tick();
      step_in = 1'b0;
      repeat (25) tick();

      // period 0 steps every clock, reverse
      dir    = 1'b1;
      period = 24'd0;
      mode   = 1'b1;
      c      = cyc;
      push(c + 1, 5, 1'b0);
      push(c + 2, 4, 1'b0);
      push(c + 3, 3, 1'b0);
      repeat (3) tick();
      mode = 1'b0;
      repeat (5) tick();

      // reset mid-debounce and mid-prescale
      dir     = 1'b0;
      period  = 24'd3;
      mode    = 1'b1;
      step_in = 1'b1;
      c       = cyc;
      push(c + 4, 4, 1'b0);
      push(c + 8, 5, 1'b0);
      repeat (10) tick();
      rst_n   = 1'b0;
      step_in = 1'b0;
      #1;
      check("async_rst_index", 64'(index), 64'(0));
      check("async_rst_seg", 64'(seg_out), 64'(0));
      check("async_rst_wrap", 64'(wrap), 64'(0));
      tick();
      rst_n = 1'b1;
      push(cyc + 4, 1, 1'b0);
      repeat (4) tick();
      mode = 1'b0;
      repeat (30) tick();

      check("pending_steps", 64'(q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
